// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - parameter defaults and channel-index width helper for the multichannel PWM
package pwm_pkg;

  localparam int PWM_NCH_DEF = 16;
  localparam int PWM_CW_DEF  = 8;
  localparam int PWM_PSW_DEF = 8;

  function automatic int ch_idx_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - prescaler and shared period counter for all PWM channels
module pwm_timebase #(
  parameter int CW  = 8,
  parameter int PSW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CW-1:0]  period,
  input  logic [PSW-1:0] prescale,
  output logic [CW-1:0]  cnt,
  output logic           tick,
  output logic           wrap
);

  logic [PSW-1:0] r_psc;
  logic [CW-1:0]  r_cnt;
  logic           w_tick;
  logic           w_wrap;

  // >= so a prescale lowered below psc ticks at once rather than after a full roll-over
  assign w_tick = (r_psc >= prescale);
  // >= so a period lowered below cnt wraps on the next tick, never overflowing
  assign w_wrap = w_tick && (r_cnt >= period);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_psc <= '0;
      r_cnt <= '0;
    end else begin
      r_psc <= w_tick ? '0 : r_psc + PSW'(1);
      if (w_wrap) begin
        r_cnt <= '0;
      end else if (w_tick) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign cnt  = r_cnt;
  assign tick = w_tick;
  assign wrap = w_wrap;

endmodule

// File: rtl/pwm_multichannel.sv
// rtl/pwm_multichannel.sv - multichannel PWM with shadowed duty registers applied at period boundaries
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int NCH = PWM_NCH_DEF,
  parameter int CW  = PWM_CW_DEF,
  parameter int PSW = PWM_PSW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCH-1:0]            en_out,
  input  logic [NCH-1:0]            en_pwm,
  input  logic [CW-1:0]             period,
  input  logic [PSW-1:0]            prescale,
  input  logic                      duty_we,
  input  logic [ch_idx_w(NCH)-1:0]  duty_ch,
  input  logic [CW-1:0]             duty_wdata,
  input  logic                      commit,
  output logic [NCH-1:0]            out,
  output logic                      period_start,
  output logic                      pending
);

  localparam int CHW = ch_idx_w(NCH);

  logic [CW-1:0]  w_cnt;
  logic           w_tick;
  logic           w_wrap;
  logic           w_apply;
  logic           w_ch_ok;
  logic [CW-1:0]  w_shadow_nxt [NCH];
  logic [NCH-1:0] w_out_nxt;

  logic [CW-1:0]  r_shadow [NCH];
  logic [CW-1:0]  r_active [NCH];
  logic [NCH-1:0] r_out;
  logic           r_pending;
  logic           r_period_start;

  pwm_timebase #(
    .CW  (CW),
    .PSW (PSW)
  ) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .period   (period),
    .prescale (prescale),
    .cnt      (w_cnt),
    .tick     (w_tick),
    .wrap     (w_wrap)
  );

  // Index range check matters only when NCH is not a power of two
  assign w_ch_ok = ({1'b0, duty_ch} < (CHW+1)'(NCH));
  assign w_apply = w_tick && w_wrap && (r_pending || commit);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    // Same-cycle write is folded in so the applying wrap copies the newest duty
    assign w_shadow_nxt[gi] = (duty_we && w_ch_ok && (duty_ch == CHW'(gi))) ?
                              duty_wdata : r_shadow[gi];
    assign w_out_nxt[gi]    = !en_out[gi] ? 1'b0 :
                              !en_pwm[gi] ? 1'b1 :
                              (w_cnt < r_active[gi]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_out          <= '0;
      r_pending      <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_shadow[i] <= w_shadow_nxt[i];
        if (w_apply) begin
          r_active[i] <= w_shadow_nxt[i];
        end
      end
      r_out          <= w_out_nxt;
      r_period_start <= w_wrap;
      if (w_apply) begin
        r_pending <= 1'b0;
      end else if (commit) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign out          = r_out;
  assign period_start = r_period_start;
  assign pending      = r_pending;

endmodule

// File: tb/tb_pwm_multichannel.sv
// tb/tb_pwm_multichannel.sv - directed self-checking bench for pwm_multichannel
module tb_pwm_multichannel;

  localparam int NCH = 16;
  localparam int CW  = 8;
  localparam int PSW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en_out;
  logic [NCH-1:0] en_pwm;
  logic [CW-1:0]  period;
  logic [PSW-1:0] prescale;
  logic           duty_we;
  logic [3:0]     duty_ch;
  logic [CW-1:0]  duty_wdata;
  logic           commit;
  logic [NCH-1:0] out;
  logic           period_start;
  logic           pending;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_multichannel #(
    .NCH (NCH),
    .CW  (CW),
    .PSW (PSW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_out       (en_out),
    .en_pwm       (en_pwm),
    .period       (period),
    .prescale     (prescale),
    .duty_we      (duty_we),
    .duty_ch      (duty_ch),
    .duty_wdata   (duty_wdata),
    .commit       (commit),
    .out          (out),
    .period_start (period_start),
    .pending      (pending)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic write_duty(input int ch, input int val);
    duty_we    = 1'b1;
    duty_ch    = 4'(ch);
    duty_wdata = CW'(val);
    step();
    duty_we    = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic wait_ps(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (period_start) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en_out = '1; en_pwm = '1; period = 8'd9; prescale = '0;
    duty_we = 1'b0; duty_ch = '0; duty_wdata = '0; commit = 1'b0;
    step(); step(); step();
    n_vec++;
    if (out !== '0) begin
      $display("FAIL reset_out: got %h expected 0000", out); n_err++;
    end
    n_vec++;
    if (pending !== 1'b0) begin
      $display("FAIL reset_pending: got %b expected 0", pending); n_err++;
    end
    n_vec++;
    if (period_start !== 1'b0) begin
      $display("FAIL reset_period_start: got %b expected 0", period_start); n_err++;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_duty();
    bit ok;
    int highs;
    logic exp;
    highs = 0;
    write_duty(0, 3);
    do_commit();
    wait_ps(200, ok);
    n_vec++;
    if (!ok) begin
      $display("FAIL basic_wait: period_start not seen expected within 200 clocks"); n_err++;
    end
    n_vec++;
    if (pending !== 1'b0) begin
      $display("FAIL basic_pending: got %b expected 0", pending); n_err++;
    end
    for (int k = 0; k < 30; k++) begin
      exp = (k != 0) && (((k - 1) % 10) < 3);
      n_vec++;
      if (out[0] !== exp) begin
        $display("FAIL basic_out0 k=%0d: got %b expected %b", k, out[0], exp); n_err++;
      end
      if (out[0] === 1'b1) highs++;
      step();
    end
    n_vec++;
    if (highs != 9) begin
      $display("FAIL basic_high_count: got %0d expected 9", highs); n_err++;
    end
  endtask

  task automatic test_extremes();
    bit ok;
    write_duty(1, 0);
    write_duty(2, 255);
    do_commit();
    wait_ps(200, ok);
    n_vec++;
    if (!ok) begin
      $display("FAIL extremes_wait: period_start not seen expected within 200 clocks"); n_err++;
    end
    step();
    for (int k = 0; k < 30; k++) begin
      n_vec++;
      if (out[1] !== 1'b0 || out[2] !== 1'b1) begin
        $display("FAIL extremes k=%0d: got out1=%b out2=%b expected out1=0 out2=1", k, out[1], out[2]);
        n_err++;
      end
      step();
    end
  endtask

  task automatic test_prescale();
    bit ok;
    int highs;
    int spurious;
    logic exp;
    highs = 0;
    spurious = 0;
    period = 8'd4; prescale = 8'd3;
    step();
    write_duty(0, 2);
    do_commit();
    wait_ps(200, ok);
    n_vec++;
    if (!ok) begin
      $display("FAIL prescale_wait: period_start not seen expected within 200 clocks"); n_err++;
    end
    for (int k = 0; k < 20; k++) begin
      exp = (k >= 1) && (k <= 8);
      n_vec++;
      if (out[0] !== exp) begin
        $display("FAIL prescale_out0 k=%0d: got %b expected %b", k, out[0], exp); n_err++;
      end
      if (out[0] === 1'b1) highs++;
      if (k > 0 && period_start !== 1'b0) spurious++;
      step();
    end
    n_vec++;
    if (period_start !== 1'b1 || spurious != 0) begin
      $display("FAIL prescale_interval: got ps@20=%b early=%0d expected 1 and 0", period_start, spurious);
      n_err++;
    end
    n_vec++;
    if (highs != 8) begin
      $display("FAIL prescale_high_count: got %0d expected 8", highs); n_err++;
    end
  endtask

  task automatic test_commit_mid();
    bit ok;
    int highs;
    int guard;
    highs = 0;
    guard = 0;
    period = 8'd9; prescale = 8'd0;
    step();
    write_duty(0, 3);
    do_commit();
    wait_ps(200, ok);
    n_vec++;
    if (!ok) begin
      $display("FAIL mid_wait: period_start not seen expected within 200 clocks"); n_err++;
    end
    step(); step(); step(); step();
    write_duty(0, 7);
    do_commit();
    n_vec++;
    if (pending !== 1'b1) begin
      $display("FAIL mid_pending_set: got %b expected 1", pending); n_err++;
    end
    while (period_start !== 1'b1 && guard < 20) begin
      n_vec++;
      if (out[0] !== 1'b0 || pending !== 1'b1) begin
        $display("FAIL mid_before_wrap: got out0=%b pending=%b expected 0 and 1", out[0], pending);
        n_err++;
      end
      step();
      guard++;
    end
    n_vec++;
    if (guard >= 20) begin
      $display("FAIL mid_wrap_timeout: got %0d clocks expected < 20", guard); n_err++;
    end
    n_vec++;
    if (pending !== 1'b0) begin
      $display("FAIL mid_pending_clear: got %b expected 0", pending); n_err++;
    end
    for (int k = 0; k < 10; k++) begin
      if (out[0] === 1'b1) highs++;
      step();
    end
    n_vec++;
    if (highs != 7) begin
      $display("FAIL mid_new_duty: got %0d high clocks expected 7", highs); n_err++;
    end
  endtask

  task automatic test_wrap_commit();
    bit ok;
    int highs;
    highs = 0;
    step();
    wait_ps(200, ok);
    n_vec++;
    if (!ok) begin
      $display("FAIL wrapc_wait: period_start not seen expected within 200 clocks"); n_err++;
    end
    for (int k = 0; k < 9; k++) step();
    duty_we = 1'b1; duty_ch = 4'd0; duty_wdata = 8'd5; commit = 1'b1;
    step();
    duty_we = 1'b0; commit = 1'b0;
    n_vec++;
    if (period_start !== 1'b1 || pending !== 1'b0) begin
      $display("FAIL wrapc_boundary: got ps=%b pending=%b expected 1 and 0", period_start, pending);
      n_err++;
    end
    for (int k = 0; k < 10; k++) begin
      if (out[0] === 1'b1) highs++;
      step();
    end
    n_vec++;
    if (highs != 5) begin
      $display("FAIL wrapc_duty: got %0d high clocks expected 5", highs); n_err++;
    end
    en_pwm[3] = 1'b0;
    en_out[4] = 1'b0;
    step();
    n_vec++;
    if (out[3] !== 1'b1) begin
      $display("FAIL static_high_ch3: got %b expected 1", out[3]); n_err++;
    end
    n_vec++;
    if (out[4] !== 1'b0) begin
      $display("FAIL disabled_ch4: got %b expected 0", out[4]); n_err++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cycles;
    cycles = 0;
    step();
    wait_ps(200, ok);
    n_vec++;
    if (!ok) begin
      $display("FAIL rstmid_wait: period_start not seen expected within 200 clocks"); n_err++;
    end
    step(); step();
    write_duty(0, 9);
    do_commit();
    n_vec++;
    if (pending !== 1'b1) begin
      $display("FAIL rstmid_pending_set: got %b expected 1", pending); n_err++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if (out !== '0 || pending !== 1'b0 || period_start !== 1'b0) begin
      $display("FAIL rstmid_state: got out=%h pending=%b ps=%b expected 0000 0 0", out, pending, period_start);
      n_err++;
    end
    for (int k = 0; k < 30; k++) begin
      step();
      cycles++;
      if (period_start === 1'b1) break;
    end
    n_vec++;
    if (cycles != 10) begin
      $display("FAIL rstmid_restart: got first period_start after %0d clocks expected 10", cycles); n_err++;
    end
    n_vec++;
    if (out[3] !== 1'b1) begin
      $display("FAIL rstmid_static_ch3: got %b expected 1", out[3]); n_err++;
    end
    do_commit();
    wait_ps(200, ok);
    n_vec++;
    if (!ok) begin
      $display("FAIL rstmid_wait2: period_start not seen expected within 200 clocks"); n_err++;
    end
    for (int k = 0; k < 10; k++) begin
      step();
      n_vec++;
      if (out[0] !== 1'b0) begin
        $display("FAIL rstmid_shadow_cleared k=%0d: got %b expected 0", k, out[0]); n_err++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_duty();
    test_extremes();
    test_prescale();
    test_commit_mid();
    test_wrap_commit();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
